// File: rtl/nps_nco_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nps_nco_ctrl
// Description : NCO sequencer for the 512-entry sine ROM. Holds a phase
//               accumulator and issues one ROM address per cycle for a
//               programmed burst length, tracks samples in flight through
//               the ROM and pulses done once all of them have returned.
// Ports       : clk, reset_x (async, active low)
//               set / start / stop        - control strobes
//               freq_in / phase_in / len_in - burst configuration
//               rom_vo                    - valid returned by the ROM
//               rom_adr / rom_vi / rom_fi - ROM address, valid, frame start
//               busy / done               - status (all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module nps_nco_ctrl #(
   parameter int ADR_WIDTH   = 9,
   parameter int PHASE_WIDTH = 24,
   parameter int LEN_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset_x,
   input  logic                   set,
   input  logic                   start,
   input  logic                   stop,
   input  logic [PHASE_WIDTH-1:0] freq_in,
   input  logic [PHASE_WIDTH-1:0] phase_in,
   input  logic [LEN_WIDTH-1:0]   len_in,
   input  logic                   rom_vo,
   output logic [ADR_WIDTH-1:0]   rom_adr,
   output logic                   rom_vi,
   output logic                   rom_fi,
   output logic                   busy,
   output logic                   done
);

   localparam logic [1:0]           c_idle    = 2'd0;
   localparam logic [1:0]           c_run     = 2'd1;
   localparam logic [1:0]           c_drain   = 2'd2;
   localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);
   localparam logic [3:0]           c_out_max = 4'd15;

   logic [1:0]             r_state;
   logic [1:0]             w_state_next;
   logic [PHASE_WIDTH-1:0] r_freq;
   logic [PHASE_WIDTH-1:0] r_phase;
   logic [LEN_WIDTH-1:0]   r_len;
   logic [PHASE_WIDTH-1:0] r_phase_acc;
   logic [LEN_WIDTH-1:0]   r_cnt;
   logic [3:0]             r_outstanding;
   logic [3:0]             w_out_next;
   logic [ADR_WIDTH-1:0]   r_rom_adr;
   logic                   r_rom_vi;
   logic                   r_rom_fi;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_load;
   logic [PHASE_WIDTH-1:0] w_freq_eff;
   logic [PHASE_WIDTH-1:0] w_phase_eff;
   logic [LEN_WIDTH-1:0]   w_len_eff;
   logic                   w_issue_first;
   logic                   w_issue_run;
   logic [ADR_WIDTH-1:0]   w_rom_adr;
   logic                   w_rom_vi;
   logic                   w_rom_fi;
   logic                   w_done;

   // A set in the same cycle as start takes effect first, so the burst
   // launches from the values on the inputs rather than the old registers.
   assign w_load      = (r_state == c_idle) && set;
   assign w_freq_eff  = w_load ? freq_in  : r_freq;
   assign w_phase_eff = w_load ? phase_in : r_phase;
   assign w_len_eff   = w_load ? len_in   : r_len;

   assign w_issue_first = (r_state == c_idle) && start && (w_len_eff != '0);
   // stop wins over issuing; cnt holds the samples still to be issued.
   assign w_issue_run   = (r_state == c_run) && !stop && (r_cnt != '0);

   // In-flight count: a sample enters when its valid is on the ROM inputs
   // and leaves when the ROM returns it; both at once cancel.
   always_comb begin
      w_out_next = r_outstanding;
      case ({r_rom_vi, rom_vo})
         2'b10:   if (r_outstanding != c_out_max) w_out_next = r_outstanding + 4'd1;
         2'b01:   if (r_outstanding != 4'd0)      w_out_next = r_outstanding - 4'd1;
         default: w_out_next = r_outstanding;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) r_state <= c_idle;
      else          r_state <= w_state_next;
   end

   // Next-state logic. DRAIN finishes on the edge that absorbs the final
   // return, so done lands in the cycle right after the last rom_vo.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_idle:  if (w_issue_first)                w_state_next = c_run;
         c_run:   if (stop || (r_cnt == '0))        w_state_next = c_drain;
         c_drain: if (w_out_next == 4'd0)           w_state_next = c_idle;
         default: w_state_next = c_idle;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      w_rom_adr = r_rom_adr;
      w_rom_vi  = 1'b0;
      w_rom_fi  = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         c_idle: begin
            if (w_issue_first) begin
               w_rom_adr = w_phase_eff[PHASE_WIDTH-1 -: ADR_WIDTH];
               w_rom_vi  = 1'b1;
               w_rom_fi  = 1'b1;
            end else if (start) begin
               w_done = 1'b1;   // zero-length burst completes at once
            end
         end
         c_run: begin
            if (w_issue_run) begin
               w_rom_adr = r_phase_acc[PHASE_WIDTH-1 -: ADR_WIDTH];
               w_rom_vi  = 1'b1;
            end
         end
         c_drain: w_done = (w_out_next == 4'd0);
         default: w_done = 1'b0;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_freq        <= '0;
         r_phase       <= '0;
         r_len         <= '0;
         r_phase_acc   <= '0;
         r_cnt         <= '0;
         r_outstanding <= 4'd0;
         r_rom_adr     <= '0;
         r_rom_vi      <= 1'b0;
         r_rom_fi      <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         if (w_load) begin
            r_freq  <= freq_in;
            r_phase <= phase_in;
            r_len   <= len_in;
         end
         if (w_issue_first) begin
            r_phase_acc <= w_phase_eff + w_freq_eff;
            r_cnt       <= w_len_eff - c_len_one;
         end else if (w_issue_run) begin
            r_phase_acc <= r_phase_acc + r_freq;   // wraps modulo 2^PHASE_WIDTH
            r_cnt       <= r_cnt - c_len_one;
         end
         r_outstanding <= w_out_next;
         r_rom_adr     <= w_rom_adr;
         r_rom_vi      <= w_rom_vi;
         r_rom_fi      <= w_rom_fi;
         r_busy        <= (w_state_next != c_idle);
         r_done        <= w_done;
      end
   end

   assign rom_adr = r_rom_adr;
   assign rom_vi  = r_rom_vi;
   assign rom_fi  = r_rom_fi;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nps_nco_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nps_nco_ctrl
// Description : Directed self-checking bench for nps_nco_ctrl with a
//               one-cycle ROM model returning rom_vo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nps_nco_ctrl;

   logic        clk = 1'b0;
   logic        reset_x;
   logic        set, start, stop;
   logic [23:0] freq_in, phase_in;
   logic [15:0] len_in;
   logic        rom_vo;
   logic [8:0]  rom_adr;
   logic        rom_vi, rom_fi, busy, done;

   int n_vec = 0;
   int n_err = 0;

   int q_adr[$];
   int fi_cnt, fi_bad, busy_bad, done_t;

   nps_nco_ctrl #(.ADR_WIDTH(9), .PHASE_WIDTH(24), .LEN_WIDTH(16)) dut (
      .clk(clk), .reset_x(reset_x), .set(set), .start(start), .stop(stop),
      .freq_in(freq_in), .phase_in(phase_in), .len_in(len_in), .rom_vo(rom_vo),
      .rom_adr(rom_adr), .rom_vi(rom_vi), .rom_fi(rom_fi), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // One-cycle ROM: returns a valid one cycle after each accepted address.
   always @(posedge clk or negedge reset_x) begin
      if (!reset_x) rom_vo <= 1'b0;
      else          rom_vo <= rom_vi;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // All driving and sampling happens on the falling edge.
   task automatic cfg(input logic [23:0] p, input logic [23:0] f, input logic [15:0] l);
      set = 1'b1; phase_in = p; freq_in = f; len_in = l;
      @(negedge clk);
      set = 1'b0;
   endtask

   // Pulse start, then observe from the first cycle after the start edge
   // (t = 0) until done or a cycle budget runs out.
   task automatic run_burst(input int stop_after, input bit set_mid);
      q_adr.delete();
      fi_cnt = 0; fi_bad = 0; busy_bad = 0; done_t = -1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < 64; t++) begin
         if (rom_vi) q_adr.push_back(int'(rom_adr));
         if (rom_fi) begin
            fi_cnt++;
            if (!(rom_vi && q_adr.size() == 1)) fi_bad++;
         end
         if (done && busy) busy_bad++;
         if (!done && !busy) busy_bad++;
         if (done) begin
            done_t = t;
            break;
         end
         stop = (stop_after > 0) && rom_vi && (q_adr.size() == stop_after);
         set  = set_mid && (t < 3);
         @(negedge clk);
      end
      stop = 1'b0;
      set  = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_burst(input string nm, input int n, input int base, input int step,
                              input int exp_done);
      check_eq({nm, "_nvi"}, q_adr.size(), n);
      for (int i = 0; i < n; i++)
         check_eq($sformatf("%s_adr%0d", nm, i),
                  (q_adr.size() > i) ? q_adr[i] : -1, (base + i * step) % 512);
      if (n > 0) begin
         check_eq({nm, "_fi_cnt"}, fi_cnt, 1);
         check_eq({nm, "_fi_pos"}, fi_bad, 0);
      end
      check_eq({nm, "_done_t"}, done_t, exp_done);
      check_eq({nm, "_busy"}, busy_bad, 0);
   endtask

   initial begin
      reset_x = 1'b0; set = 1'b0; start = 1'b0; stop = 1'b0;
      freq_in = '0; phase_in = '0; len_in = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_adr",  rom_adr, 0);
      check_eq("rst_vi",   rom_vi,  0);
      check_eq("rst_fi",   rom_fi,  0);
      check_eq("rst_busy", busy,    0);
      check_eq("rst_done", done,    0);
      reset_x = 1'b1;
      @(negedge clk);

      // Basic burst: addresses 0..3, done one cycle after the 4th return.
      cfg(24'h000000, 24'h008000, 16'd4);
      run_burst(0, 1'b0);
      check_burst("basic", 4, 0, 1, 5);

      // Phase wrap: 511, 0, 1.
      cfg(24'hFF8000, 24'h008000, 16'd3);
      run_burst(0, 1'b0);
      check_burst("wrap", 3, 511, 1, 4);

      // Zero length: immediate done, nothing issued, never busy.
      cfg(24'h000000, 24'h008000, 16'd0);
      run_burst(0, 1'b0);
      check_burst("zero", 0, 0, 0, 0);

      // Stop during the fifth issue slot: exactly four samples.
      cfg(24'h000000, 24'h008000, 16'd100);
      run_burst(4, 1'b0);
      check_burst("stop", 4, 0, 1, 5);

      // Set while busy is ignored; the next burst still steps by one.
      cfg(24'h000000, 24'h008000, 16'd4);
      freq_in = 24'h010000;
      run_burst(0, 1'b1);
      check_burst("ignset", 4, 0, 1, 5);
      run_burst(0, 1'b0);
      check_burst("ignset2", 4, 0, 1, 5);

      // Zero frequency repeats one address (0x123456 -> 36).
      cfg(24'h123456, 24'h000000, 16'd3);
      run_burst(0, 1'b0);
      check_burst("freq0", 3, 36, 0, 4);

      // Reset mid-burst: outputs clear asynchronously, config returns to 0.
      cfg(24'h000000, 24'h008000, 16'd100);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("mid_vi_pre", rom_vi, 1);
      #1 reset_x = 1'b0;
      #1;
      check_eq("mid_adr",  rom_adr, 0);
      check_eq("mid_vi",   rom_vi,  0);
      check_eq("mid_fi",   rom_fi,  0);
      check_eq("mid_busy", busy,    0);
      check_eq("mid_done", done,    0);
      repeat (2) @(negedge clk);
      reset_x = 1'b1;
      @(negedge clk);
      run_burst(0, 1'b0);
      check_burst("postrst", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
